// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// Contents:
//   control          packed {stall, flush} pair driven to each pipeline register
//   writebackType_   source of the value a stage will eventually write back
//   forwardSelect_   operand source select for the execute stage
//   hazardState_     sequencing states of the hazard controller
//   resetVector      PC loaded on the first cycle after reset
//   trapVector       PC loaded when an illegal instruction traps
package pipeline_hazard_controller_pkg;

    typedef struct packed {
        logic stall;
        logic flush;
    } control;

    localparam control CTRL_NONE  = '{stall: 1'b0, flush: 1'b0};
    localparam control CTRL_STALL = '{stall: 1'b1, flush: 1'b0};
    localparam control CTRL_FLUSH = '{stall: 1'b0, flush: 1'b1};

    typedef enum logic [2:0] {
        WB_NONE = 3'd0,
        WB_ALU  = 3'd1,
        WB_MEM  = 3'd2,
        WB_PC4  = 3'd3
    } writebackType_;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } forwardSelect_;

    typedef enum logic [1:0] {
        RESET_REDIRECT = 2'd0,
        RUN            = 2'd1,
        TRAP_DRAIN     = 2'd2,
        TRAP_REDIRECT  = 2'd3
    } hazardState_;

    localparam logic [31:0] resetVector = 32'h0000_0000;
    localparam logic [31:0] trapVector  = 32'h0000_0000;

    // Only results that already exist at the end of execute can be bypassed
    // from the memory stage; load data is not available until writeback.
    function automatic logic memForwardable(input writebackType_ wb_type);
        return (wb_type == WB_ALU) || (wb_type == WB_PC4);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_forward_select.sv
// Combinational operand-forwarding selector for one execute-stage source.
// Ports:
//   src             in  5  source register index of the operand in execute
//   memoryValid     in  1  execute->memory register holds a valid instruction
//   memoryRd        in  5  destination of the instruction in memory
//   memoryWbType    in  3  writeback type of the instruction in memory
//   writebackValid  in  1  memory->writeback register holds a valid instruction
//   writebackEnable in  1  instruction in writeback writes the register file
//   writebackRd     in  5  destination of the instruction in writeback
//   select          out 2  FWD_REG / FWD_MEM / FWD_WB
module forward_select
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [4:0]    src,
    input  logic          memoryValid,
    input  logic [4:0]    memoryRd,
    input  logic [2:0]    memoryWbType,
    input  logic          writebackValid,
    input  logic          writebackEnable,
    input  logic [4:0]    writebackRd,
    output forwardSelect_ select
);

    // The memory stage is the younger producer, so it wins over writeback.
    // x0 is hardwired to zero and must always come from the register file.
    always_comb begin
        select = FWD_REG;
        if (src != 5'd0) begin
            if (memoryValid && (memoryRd == src) &&
                memForwardable(writebackType_'(memoryWbType))) begin
                select = FWD_MEM;
            end else if (writebackValid && writebackEnable && (writebackRd == src)) begin
                select = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/redirect sequencer for the 5-stage RV32I pipeline.
// Detects load-use hazards, picks execute operand forwarding, applies memory
// wait stalls and redirects fetch on taken branches/jumps. A small FSM loads
// the reset vector after reset and sequences illegal-instruction traps.
// Ports:
//   clock, resetN                      clock and async active-low reset
//   decode*/execute*/memory*/writeback* per-stage hazard information
//   imemWait, dmemWait                 memory not ready this cycle
//   fetch/decode/execute/memory/writebackControl  {stall,flush} per register
//   forwardRs1, forwardRs2             execute operand source selects
//   pcRedirectValid, pcRedirectTarget  PC load request and value
//   trapPc                             PC of last trapping instruction
//   trapActive                         trap sequence in progress
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = resetVector,
    parameter logic [31:0] TRAP_VECTOR  = trapVector
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        decodeValid,
    input  logic [4:0]  decodeRs1,
    input  logic [4:0]  decodeRs2,
    input  logic        decodeUsesRs1,
    input  logic        decodeUsesRs2,
    input  logic        executeValid,
    input  logic [4:0]  executeRs1,
    input  logic [4:0]  executeRs2,
    input  logic [4:0]  executeRd,
    input  logic        executeMemRead,
    input  logic        executeRedirect,
    input  logic [31:0] executeTarget,
    input  logic        memoryValid,
    input  logic [4:0]  memoryRd,
    input  logic [2:0]  memoryWbType,
    input  logic        writebackValid,
    input  logic [4:0]  writebackRd,
    input  logic        writebackEnable,
    input  logic        writebackIllegal,
    input  logic [31:0] writebackPc,
    input  logic        imemWait,
    input  logic        dmemWait,
    output logic [1:0]  fetchControl,
    output logic [1:0]  decodeControl,
    output logic [1:0]  executeControl,
    output logic [1:0]  memoryControl,
    output logic [1:0]  writebackControl,
    output logic [1:0]  forwardRs1,
    output logic [1:0]  forwardRs2,
    output logic        pcRedirectValid,
    output logic [31:0] pcRedirectTarget,
    output logic [31:0] trapPc,
    output logic        trapActive
);

    hazardState_   state;
    hazardState_   state_next;
    control        fetch_ctrl;
    control        decode_ctrl;
    control        execute_ctrl;
    control        memory_ctrl;
    control        writeback_ctrl;
    forwardSelect_ fwd_rs1;
    forwardSelect_ fwd_rs2;
    logic          trap_take;
    logic          load_use;

    assign trap_take = (state == RUN) && writebackValid && writebackIllegal;

    // A load in execute whose destination is read by the instruction in
    // decode cannot be bypassed in time; one bubble lets it reach writeback.
    assign load_use = executeValid && executeMemRead && (executeRd != 5'd0) && decodeValid &&
                      ((decodeUsesRs1 && (decodeRs1 == executeRd)) ||
                       (decodeUsesRs2 && (decodeRs2 == executeRd)));

    // State register; trapPc captures the faulting PC on entry to the drain.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state  <= RESET_REDIRECT;
            trapPc <= 32'h0000_0000;
        end else begin
            state <= state_next;
            if (trap_take) begin
                trapPc <= writebackPc;
            end
        end
    end

    // All controls are derived combinationally from the current state and
    // inputs so each hazard is acted on in the cycle it is detected.
    always_comb begin
        state_next       = state;
        fetch_ctrl       = CTRL_NONE;
        decode_ctrl      = CTRL_NONE;
        execute_ctrl     = CTRL_NONE;
        memory_ctrl      = CTRL_NONE;
        writeback_ctrl   = CTRL_NONE;
        pcRedirectValid  = 1'b0;
        pcRedirectTarget = 32'h0000_0000;
        case (state)
            RESET_REDIRECT: begin
                pcRedirectValid  = 1'b1;
                pcRedirectTarget = RESET_VECTOR;
                decode_ctrl      = CTRL_FLUSH;
                execute_ctrl     = CTRL_FLUSH;
                memory_ctrl      = CTRL_FLUSH;
                writeback_ctrl   = CTRL_FLUSH;
                state_next       = RUN;
            end
            RUN: begin
                if (trap_take) begin
                    // Freeze fetch and empty the pipe while any dmem access drains.
                    fetch_ctrl     = CTRL_STALL;
                    decode_ctrl    = CTRL_FLUSH;
                    execute_ctrl   = CTRL_FLUSH;
                    memory_ctrl    = CTRL_FLUSH;
                    writeback_ctrl = CTRL_FLUSH;
                    state_next     = TRAP_DRAIN;
                end else if (dmemWait) begin
                    // Hold everything up to memory; a pending redirect in
                    // execute is retried once the memory stage completes.
                    fetch_ctrl     = CTRL_STALL;
                    decode_ctrl    = CTRL_STALL;
                    execute_ctrl   = CTRL_STALL;
                    memory_ctrl    = CTRL_STALL;
                    writeback_ctrl = CTRL_FLUSH;
                end else if (executeRedirect) begin
                    // Fetch is not stalled even under imemWait: the redirect
                    // makes it re-issue from the new target.
                    pcRedirectValid  = 1'b1;
                    pcRedirectTarget = executeTarget;
                    decode_ctrl      = CTRL_FLUSH;
                    execute_ctrl     = CTRL_FLUSH;
                end else if (load_use) begin
                    fetch_ctrl   = CTRL_STALL;
                    decode_ctrl  = CTRL_STALL;
                    execute_ctrl = CTRL_FLUSH;
                end else if (imemWait) begin
                    fetch_ctrl  = CTRL_STALL;
                    decode_ctrl = CTRL_FLUSH;
                end
            end
            TRAP_DRAIN: begin
                fetch_ctrl     = CTRL_STALL;
                decode_ctrl    = CTRL_FLUSH;
                execute_ctrl   = CTRL_FLUSH;
                memory_ctrl    = CTRL_FLUSH;
                writeback_ctrl = CTRL_FLUSH;
                if (!dmemWait) begin
                    state_next = TRAP_REDIRECT;
                end
            end
            TRAP_REDIRECT: begin
                pcRedirectValid  = 1'b1;
                pcRedirectTarget = TRAP_VECTOR;
                decode_ctrl      = CTRL_FLUSH;
                execute_ctrl     = CTRL_FLUSH;
                memory_ctrl      = CTRL_FLUSH;
                writeback_ctrl   = CTRL_FLUSH;
                state_next       = RUN;
            end
            default: begin
                state_next = RESET_REDIRECT;
            end
        endcase
    end

    forward_select u_forward_rs1 (
        .src             (executeRs1),
        .memoryValid     (memoryValid),
        .memoryRd        (memoryRd),
        .memoryWbType    (memoryWbType),
        .writebackValid  (writebackValid),
        .writebackEnable (writebackEnable),
        .writebackRd     (writebackRd),
        .select          (fwd_rs1)
    );

    forward_select u_forward_rs2 (
        .src             (executeRs2),
        .memoryValid     (memoryValid),
        .memoryRd        (memoryRd),
        .memoryWbType    (memoryWbType),
        .writebackValid  (writebackValid),
        .writebackEnable (writebackEnable),
        .writebackRd     (writebackRd),
        .select          (fwd_rs2)
    );

    assign fetchControl     = fetch_ctrl;
    assign decodeControl    = decode_ctrl;
    assign executeControl   = execute_ctrl;
    assign memoryControl    = memory_ctrl;
    assign writebackControl = writeback_ctrl;
    assign forwardRs1       = fwd_rs1;
    assign forwardRs2       = fwd_rs2;
    assign trapActive       = (state == TRAP_DRAIN) || (state == TRAP_REDIRECT);

endmodule
